mips_dmem_responder: RTL and testbench

MIPS_DMEM_RESPONDER -- requirements
Module: mips_dmem_responder

---
 rtl/mips_mem_pkg.sv | 43 ++++
 rtl/mips_mem_array.sv | 38 +++
 rtl/mips_dmem_responder.sv | 149 ++++++++++++++
 tb/tb_mips_dmem_responder.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// ---------------------------------------------------------------------------
// mips_mem_pkg
// Shared definitions for the MIPS data-memory responder and its storage array.
//   state_t            : responder FSM states (IDLE / BUSY / RESP)
//   DATA_START_DEFAULT : default byte base address of the data segment
//   CNT_W              : width of the latency countdown (latency 1..15)
//   addr_in_window()   : inclusive word-address window test
//   byte_merge()       : lane-masked merge of store data into a word
// ---------------------------------------------------------------------------
package mips_mem_pkg;

   localparam logic [31:0] DATA_START_DEFAULT = 32'h1000_0000;
   localparam int          CNT_W              = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   // Compared in 32 bits so that a window ending at the top of the 30-bit
   // word space does not wrap.
   function automatic logic addr_in_window(input logic [29:0] addr,
                                           input logic [29:0] first,
                                           input logic [31:0] last);
      return ({2'b00, addr} >= {2'b00, first}) && ({2'b00, addr} <= last);
   endfunction

   // Mask bit n selects byte lane n (bit3 -> [31:24] ... bit0 -> [7:0]).
   function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  lane_mask);
      logic [31:0] merged;
      merged = old_word;
      for (int b = 0; b < 4; b++) begin
         if (lane_mask[b]) begin
            merged[8*b +: 8] = new_word[8*b +: 8];
         end
      end
      return merged;
   endfunction

endpackage

// File: rtl/mips_mem_array.sv
// ---------------------------------------------------------------------------
// mips_mem_array
// depth_words x 32 storage with a synchronous byte-enable write port and a
// combinational read port. Contents are deliberately not reset.
//   clk      in  : write clock
//   i_we     in  : write strobe
//   i_be     in  : byte-lane enables for the write
//   i_waddr  in  : write word index
//   i_wdata  in  : write data
//   i_raddr  in  : read word index
//   o_rdata  out : read data (combinational)
// ---------------------------------------------------------------------------
module mips_mem_array
   import mips_mem_pkg::*;
#(
   parameter int depth_words = 1024,
   parameter int AW          = (depth_words > 1) ? $clog2(depth_words) : 1
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [3:0]    i_be,
   input  logic [AW-1:0] i_waddr,
   input  logic [31:0]   i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [31:0]   o_rdata
);

   logic [31:0] r_mem [depth_words];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= byte_merge(r_mem[i_waddr], i_wdata, i_be);
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mips_dmem_responder.sv
// ---------------------------------------------------------------------------
// mips_dmem_responder
// Single-outstanding data-memory responder for a MIPS core. A request is
// accepted on req_valid & req_ready; the response appears `latency` cycles
// after the accepting edge as a one-cycle rsp_valid pulse. Addresses outside
// the data segment answer with mem_excpt and never touch the array.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | nothing outstanding, ready for a request
//   BUSY  | request latched, counting down to its response
//   RESP  | response cycle; writes commit at the edge leaving this state,
//         | and a new request may be accepted back-to-back
//
// Ports:
//   clk          in  : clock, rising edge
//   rst_b        in  : asynchronous active-low reset
//   req_valid    in  : core presents a request
//   req_ready    out : responder can accept this cycle (low only in BUSY)
//   mem_addr     in  : word address (byte address [31:2])
//   mem_write_en in  : byte-lane write mask, 0 = read
//   mem_data_in  in  : store data
//   rsp_valid    out : one-cycle response strobe
//   mem_data_out out : load data, 0 for writes/errors and outside rsp_valid
//   mem_excpt    out : address error, qualified by rsp_valid
// ---------------------------------------------------------------------------
module mips_dmem_responder
   import mips_mem_pkg::*;
#(
   parameter logic [31:0] data_start  = DATA_START_DEFAULT,
   parameter int          depth_words = 1024,
   parameter int          latency     = 2
) (
   input  logic        clk,
   input  logic        rst_b,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [29:0] mem_addr,
   input  logic [3:0]  mem_write_en,
   input  logic [31:0] mem_data_in,
   output logic        rsp_valid,
   output logic [31:0] mem_data_out,
   output logic        mem_excpt
);

   localparam int               AW       = (depth_words > 1) ? $clog2(depth_words) : 1;
   localparam logic [29:0]      BASE_WA  = data_start[31:2];
   localparam logic [31:0]      LAST_WA  = {2'b00, BASE_WA} + 32'(depth_words) - 32'd1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(latency - 1);
   localparam logic             LAT_ONE  = (latency == 1);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_req_ready;
   logic             r_rsp_valid;
   logic             r_in_range;
   logic [AW-1:0]    r_idx;
   logic [3:0]       r_we;
   logic [31:0]      r_wdata;

   logic             w_accept;
   logic             w_in_range;
   logic [AW-1:0]    w_idx;
   logic             w_arr_we;
   logic [31:0]      w_rdata;

   assign w_accept   = req_valid & r_req_ready;
   assign w_in_range = addr_in_window(mem_addr, BASE_WA, LAST_WA);
   assign w_idx      = AW'(mem_addr - BASE_WA);

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_req_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_in_range  <= 1'b0;
         r_idx       <= '0;
         r_we        <= 4'b0000;
         r_wdata     <= 32'h0;
      end else begin
         case (r_state)
            IDLE, RESP: begin
               if (w_accept) begin
                  r_in_range <= w_in_range;
                  r_idx      <= w_idx;
                  r_we       <= mem_write_en;
                  r_wdata    <= mem_data_in;
                  r_cnt      <= CNT_LOAD;
                  if (LAT_ONE) begin
                     r_state     <= RESP;
                     r_req_ready <= 1'b1;
                     r_rsp_valid <= 1'b1;
                  end else begin
                     r_state     <= BUSY;
                     r_req_ready <= 1'b0;
                     r_rsp_valid <= 1'b0;
                  end
               end else begin
                  r_state     <= IDLE;
                  r_req_ready <= 1'b1;
                  r_rsp_valid <= 1'b0;
               end
            end
            BUSY: begin
               // The edge that takes the count to zero is the one that
               // enters RESP, so the response lands latency-1 edges after
               // the accepting edge.
               r_cnt <= r_cnt - 1'b1;
               if (r_cnt == CNT_W'(1)) begin
                  r_state     <= RESP;
                  r_req_ready <= 1'b1;
                  r_rsp_valid <= 1'b1;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_req_ready <= 1'b1;
               r_rsp_valid <= 1'b0;
            end
         endcase
      end
   end

   // r_rsp_valid is high exactly in RESP, so a reset during BUSY/RESP
   // kills the pending commit along with the response.
   assign w_arr_we = r_rsp_valid & r_in_range & (r_we != 4'b0000);

   mips_mem_array #(
      .depth_words (depth_words),
      .AW          (AW)
   ) u_array (
      .clk     (clk),
      .i_we    (w_arr_we),
      .i_be    (r_we),
      .i_waddr (r_idx),
      .i_wdata (r_wdata),
      .i_raddr (r_idx),
      .o_rdata (w_rdata)
   );

   // Read data comes straight off the array during RESP so a read accepted
   // back-to-back behind a write sees the word that write just committed.
   assign req_ready    = r_req_ready;
   assign rsp_valid    = r_rsp_valid;
   assign mem_excpt    = r_rsp_valid & ~r_in_range;
   assign mem_data_out = (r_rsp_valid && r_in_range && (r_we == 4'b0000)) ? w_rdata : 32'h0;

endmodule

// File: tb/tb_mips_dmem_responder.sv
module tb_mips_dmem_responder;

   localparam logic [29:0] BASE   = 30'h0400_0000;
   localparam int          DEPTH  = 1024;
   localparam int          DEPTH1 = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_b;
   logic        req_valid, req_ready, rsp_valid, mem_excpt;
   logic [29:0] mem_addr;
   logic [3:0]  mem_write_en;
   logic [31:0] mem_data_in, mem_data_out;
   logic        req_valid_1, req_ready_1, rsp_valid_1, mem_excpt_1;
   logic [29:0] mem_addr_1;
   logic [3:0]  mem_write_en_1;
   logic [31:0] mem_data_in_1, mem_data_out_1;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] mdl  [int];
   logic [31:0] mdl1 [int];

   mips_dmem_responder #(.data_start(32'h1000_0000), .depth_words(DEPTH), .latency(2)) dut (
      .clk(clk), .rst_b(rst_b), .req_valid(req_valid), .req_ready(req_ready),
      .mem_addr(mem_addr), .mem_write_en(mem_write_en), .mem_data_in(mem_data_in),
      .rsp_valid(rsp_valid), .mem_data_out(mem_data_out), .mem_excpt(mem_excpt));

   mips_dmem_responder #(.data_start(32'h1000_0000), .depth_words(DEPTH1), .latency(1)) dut1 (
      .clk(clk), .rst_b(rst_b), .req_valid(req_valid_1), .req_ready(req_ready_1),
      .mem_addr(mem_addr_1), .mem_write_en(mem_write_en_1), .mem_data_in(mem_data_in_1),
      .rsp_valid(rsp_valid_1), .mem_data_out(mem_data_out_1), .mem_excpt(mem_excpt_1));

   // ---------------- reference model ----------------
   function automatic logic [29:0] wa(input int off);
      return 30'(int'(BASE) + off);
   endfunction

   function automatic bit in_rng(input logic [29:0] a, input int depth);
      longint d;
      d = longint'(a) - longint'(BASE);
      return (d >= 0) && (d < longint'(depth));
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] m);
      logic [31:0] r;
      r = o;
      for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   function automatic void mdl_commit(input bit which, input logic [29:0] a, input logic [3:0] we, input logic [31:0] d);
      int idx;
      if (!in_rng(a, which ? DEPTH1 : DEPTH) || we == 4'b0000) return;
      idx = int'(a) - int'(BASE);
      if (which) mdl1[idx] = merge(mdl1.exists(idx) ? mdl1[idx] : 32'h0, d, we);
      else       mdl[idx]  = merge(mdl.exists(idx)  ? mdl[idx]  : 32'h0, d, we);
   endfunction

   function automatic void mdl_expect(input bit which, input logic [29:0] a, input logic [3:0] we,
                                      output logic [31:0] ed, output logic ee, output bit known);
      int idx;
      ed = 32'h0; ee = 1'b0; known = 1'b1;
      if (!in_rng(a, which ? DEPTH1 : DEPTH)) begin
         ee = 1'b1;
      end else if (we == 4'b0000) begin
         idx = int'(a) - int'(BASE);
         if (which) begin known = mdl1.exists(idx); if (known) ed = mdl1[idx]; end
         else       begin known = mdl.exists(idx);  if (known) ed = mdl[idx];  end
      end
   endfunction

   // One request on the latency-2 instance; returns what was observed.
   task automatic txn(input logic [29:0] a, input logic [3:0] we, input logic [31:0] d,
                      output int lat, output logic [31:0] rd, output logic re,
                      output logic busy_rdy, output logic after_v);
      req_valid = 1'b1; mem_addr = a; mem_write_en = we; mem_data_in = d;
      @(posedge clk); #1;
      req_valid = 1'b0;
      mem_addr = 30'($urandom); mem_write_en = 4'($urandom); mem_data_in = $urandom;
      busy_rdy = req_ready;
      lat = 1;
      while (rsp_valid !== 1'b1 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      rd = mem_data_out; re = mem_excpt;
      @(posedge clk); #1;
      after_v = rsp_valid;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_b = 1'b0;
      req_valid = 1'b1; mem_addr = BASE; mem_write_en = 4'hF; mem_data_in = 32'h1234_5678;
      req_valid_1 = 1'b1; mem_addr_1 = BASE; mem_write_en_1 = 4'hF; mem_data_in_1 = 32'h1;
      repeat (3) @(posedge clk);
      #1;
      n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got=%b exp=1", req_ready); end
      n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp got=%b exp=0", rsp_valid); end
      n_vec++; if (mem_data_out !== 32'h0) begin n_err++; $display("FAIL rst_data got=%h exp=0", mem_data_out); end
      n_vec++; if (mem_excpt !== 1'b0) begin n_err++; $display("FAIL rst_excpt got=%b exp=0", mem_excpt); end
      n_vec++; if (req_ready_1 !== 1'b1 || rsp_valid_1 !== 1'b0 || mem_excpt_1 !== 1'b0 || mem_data_out_1 !== 32'h0) begin
         n_err++; $display("FAIL rst_dut1 got=%b%b%b/%h exp=100/0", req_ready_1, rsp_valid_1, mem_excpt_1, mem_data_out_1);
      end
      req_valid = 1'b0; req_valid_1 = 1'b0;
      rst_b = 1'b1;
      @(posedge clk); #1;
      n_vec++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
         n_err++; $display("FAIL post_rst got=%b%b exp=01", rsp_valid, req_ready);
      end
   endtask

   task automatic test_write_read();
      int lat; logic [31:0] rd; logic re, br, av;
      txn(BASE, 4'hF, 32'hDEAD_BEEF, lat, rd, re, br, av);
      mdl_commit(0, BASE, 4'hF, 32'hDEAD_BEEF);
      n_vec++; if (lat !== 2) begin n_err++; $display("FAIL wr_lat got=%0d exp=2", lat); end
      n_vec++; if (rd !== 32'h0 || re !== 1'b0) begin n_err++; $display("FAIL wr_rsp got=%h/%b exp=0/0", rd, re); end
      n_vec++; if (br !== 1'b0) begin n_err++; $display("FAIL busy_ready got=%b exp=0", br); end
      n_vec++; if (av !== 1'b0) begin n_err++; $display("FAIL wr_pulse got=%b exp=0", av); end
      txn(BASE, 4'h0, 32'h0, lat, rd, re, br, av);
      n_vec++; if (lat !== 2) begin n_err++; $display("FAIL rd_lat got=%0d exp=2", lat); end
      n_vec++; if (rd !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL rd_data got=%h exp=deadbeef", rd); end
      n_vec++; if (re !== 1'b0) begin n_err++; $display("FAIL rd_excpt got=%b exp=0", re); end
   endtask

   task automatic test_partial();
      int lat; logic [31:0] rd; logic re, br, av;
      txn(BASE, 4'b0010, 32'h0000_AB00, lat, rd, re, br, av);
      mdl_commit(0, BASE, 4'b0010, 32'h0000_AB00);
      txn(BASE, 4'h0, 32'h0, lat, rd, re, br, av);
      n_vec++; if (rd !== 32'hDEAD_ABEF) begin n_err++; $display("FAIL partial got=%h exp=deadabef", rd); end
   endtask

   task automatic test_out_of_range();
      int lat; logic [31:0] rd; logic re, br, av;
      txn(30'h10, 4'h0, 32'h0, lat, rd, re, br, av);
      n_vec++; if (re !== 1'b1 || rd !== 32'h0) begin n_err++; $display("FAIL oor_low got=%b/%h exp=1/0", re, rd); end
      n_vec++; if (lat !== 2) begin n_err++; $display("FAIL oor_lat got=%0d exp=2", lat); end
      txn(wa(DEPTH-1), 4'hF, 32'h0BAD_F00D, lat, rd, re, br, av);
      mdl_commit(0, wa(DEPTH-1), 4'hF, 32'h0BAD_F00D);
      n_vec++; if (re !== 1'b0) begin n_err++; $display("FAIL top_wr_excpt got=%b exp=0", re); end
      txn(wa(DEPTH), 4'hF, 32'hFFFF_FFFF, lat, rd, re, br, av);
      n_vec++; if (re !== 1'b1 || rd !== 32'h0) begin n_err++; $display("FAIL oor_high got=%b/%h exp=1/0", re, rd); end
      txn(wa(DEPTH-1), 4'h0, 32'h0, lat, rd, re, br, av);
      n_vec++; if (rd !== 32'h0BAD_F00D || re !== 1'b0) begin n_err++; $display("FAIL top_rd got=%h/%b exp=0badf00d/0", rd, re); end
      txn(BASE, 4'h0, 32'h0, lat, rd, re, br, av);
      n_vec++; if (rd !== 32'hDEAD_ABEF) begin n_err++; $display("FAIL oor_nowrite got=%h exp=deadabef", rd); end
      txn(wa(-1), 4'h0, 32'h0, lat, rd, re, br, av);
      n_vec++; if (re !== 1'b1) begin n_err++; $display("FAIL oor_base_m1 got=%b exp=1", re); end
   endtask

   task automatic test_back_to_back();
      logic [29:0] qa [3];
      logic [3:0]  qw [3];
      logic [31:0] qd [3];
      int acc [$];
      int rsp [$];
      int nacc, nrsp;
      logic [31:0] ed; logic ee; bit kn;
      logic exp_rdy;
      qa[0] = wa(5); qw[0] = 4'hF; qd[0] = 32'h1111_1111;
      qa[1] = wa(5); qw[1] = 4'h0; qd[1] = 32'h0;
      qa[2] = 30'h10; qw[2] = 4'h0; qd[2] = 32'h0;
      nacc = 0; nrsp = 0;
      for (int c = 0; c < 10; c++) begin
         exp_rdy = !(c == 1 || c == 3 || c == 5);
         n_vec++; if (req_ready !== exp_rdy) begin n_err++; $display("FAIL b2b_ready c=%0d got=%b exp=%b", c, req_ready, exp_rdy); end
         if (rsp_valid === 1'b1) begin
            rsp.push_back(c);
            if (nrsp < 3) begin
               mdl_expect(0, qa[nrsp], qw[nrsp], ed, ee, kn);
               n_vec++; if (mem_excpt !== ee || (kn && mem_data_out !== ed)) begin
                  n_err++; $display("FAIL b2b_rsp%0d got=%h/%b exp=%h/%b", nrsp, mem_data_out, mem_excpt, ed, ee);
               end
               mdl_commit(0, qa[nrsp], qw[nrsp], qd[nrsp]);
            end
            nrsp++;
         end
         if (nacc < 3 && req_ready === 1'b1) begin
            acc.push_back(c);
            req_valid = 1'b1; mem_addr = qa[nacc]; mem_write_en = qw[nacc]; mem_data_in = qd[nacc];
            nacc++;
         end else if (nacc < 3) begin
            // held valid with junk during BUSY; must be ignored
            req_valid = 1'b1; mem_addr = BASE; mem_write_en = 4'hF; mem_data_in = $urandom;
         end else begin
            req_valid = 1'b0;
         end
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      n_vec++; if (acc.size() != 3 || acc[0] != 0 || acc[1] != 2 || acc[2] != 4) begin
         n_err++; $display("FAIL b2b_accepts got=%p exp=0,2,4", acc);
      end
      n_vec++; if (rsp.size() != 3 || rsp[0] != 2 || rsp[1] != 4 || rsp[2] != 6) begin
         n_err++; $display("FAIL b2b_pulses got=%p exp=2,4,6", rsp);
      end
   endtask

   task automatic test_reset_mid();
      int lat; logic [31:0] rd; logic re, br, av;
      int pulses;
      txn(wa(7), 4'hF, 32'hAAAA_5555, lat, rd, re, br, av);
      mdl_commit(0, wa(7), 4'hF, 32'hAAAA_5555);
      // reset in BUSY
      req_valid = 1'b1; mem_addr = wa(7); mem_write_en = 4'hF; mem_data_in = 32'h1234_5678;
      @(posedge clk); #1;
      req_valid = 1'b0;
      rst_b = 1'b0;
      #1;
      n_vec++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         n_err++; $display("FAIL midrst_outs got=%b%b exp=10", req_ready, rsp_valid);
      end
      @(posedge clk); #1;
      rst_b = 1'b1;
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         if (rsp_valid === 1'b1) pulses++;
         @(posedge clk); #1;
      end
      n_vec++; if (pulses != 0) begin n_err++; $display("FAIL midrst_pulses got=%0d exp=0", pulses); end
      txn(wa(7), 4'h0, 32'h0, lat, rd, re, br, av);
      n_vec++; if (rd !== 32'hAAAA_5555) begin n_err++; $display("FAIL midrst_busy_data got=%h exp=aaaa5555", rd); end
      // reset during RESP: the write must not commit
      req_valid = 1'b1; mem_addr = wa(7); mem_write_en = 4'hF; mem_data_in = 32'h7777_7777;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL midrst_resp got=%b exp=1", rsp_valid); end
      rst_b = 1'b0;
      @(posedge clk); #1;
      rst_b = 1'b1;
      @(posedge clk); #1;
      txn(wa(7), 4'h0, 32'h0, lat, rd, re, br, av);
      n_vec++; if (rd !== 32'hAAAA_5555) begin n_err++; $display("FAIL midrst_resp_data got=%h exp=aaaa5555", rd); end
   endtask

   task automatic test_random();
      int lat; logic [31:0] rd; logic re, br, av;
      logic [29:0] pool [24];
      logic [29:0] a; logic [3:0] we; logic [31:0] d;
      logic [31:0] ed; logic ee; bit kn;
      for (int i = 0; i < 16; i++) pool[i] = wa(i);
      for (int i = 0; i < 4; i++) pool[16+i] = wa(DEPTH-4+i);
      pool[20] = wa(-1); pool[21] = wa(DEPTH); pool[22] = 30'h0; pool[23] = 30'h3FFF_FFFF;
      for (int i = 0; i < 20; i++) begin
         d = $urandom;
         txn(pool[i], 4'hF, d, lat, rd, re, br, av);
         mdl_commit(0, pool[i], 4'hF, d);
      end
      for (int i = 0; i < 40; i++) begin
         a  = pool[$urandom_range(0, 23)];
         we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
         d  = $urandom;
         mdl_expect(0, a, we, ed, ee, kn);
         txn(a, we, d, lat, rd, re, br, av);
         n_vec++; if (lat !== 2 || re !== ee || (kn && rd !== ed) || av !== 1'b0) begin
            n_err++; $display("FAIL rnd%0d a=%h we=%h got=%0d/%h/%b/%b exp=2/%h/%b/0", i, a, we, lat, rd, re, av, ed, ee);
         end
         mdl_commit(0, a, we, d);
      end
   endtask

   task automatic test_latency1();
      localparam int N = 36;
      logic [29:0] qa [N];
      logic [3:0]  qw [N];
      logic [31:0] qd [N];
      logic [31:0] ed; logic ee; bit kn;
      int pick;
      for (int i = 0; i < N; i++) begin
         if (i < 16) begin
            qa[i] = wa(i); qw[i] = 4'hF;
         end else begin
            pick = $urandom_range(0, 18);
            qa[i] = (pick == 18) ? wa(-1) : wa(pick);
            qw[i] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
         end
         qd[i] = $urandom;
      end
      // read right behind a write to the same word
      qa[20] = wa(3); qw[20] = 4'b1001; qa[21] = wa(3); qw[21] = 4'h0;
      for (int c = 0; c <= N; c++) begin
         if (c > 0) begin
            mdl_expect(1, qa[c-1], qw[c-1], ed, ee, kn);
            n_vec++; if (rsp_valid_1 !== 1'b1 || req_ready_1 !== 1'b1 || mem_excpt_1 !== ee || (kn && mem_data_out_1 !== ed)) begin
               n_err++; $display("FAIL lat1_rsp%0d got=%b%b/%h/%b exp=11/%h/%b", c-1, rsp_valid_1, req_ready_1, mem_data_out_1, mem_excpt_1, ed, ee);
            end
            mdl_commit(1, qa[c-1], qw[c-1], qd[c-1]);
         end
         if (c < N) begin
            req_valid_1 = 1'b1; mem_addr_1 = qa[c]; mem_write_en_1 = qw[c]; mem_data_in_1 = qd[c];
         end else begin
            req_valid_1 = 1'b0;
         end
         @(posedge clk); #1;
      end
      n_vec++; if (rsp_valid_1 !== 1'b0 || mem_data_out_1 !== 32'h0 || mem_excpt_1 !== 1'b0) begin
         n_err++; $display("FAIL lat1_idle got=%b/%h/%b exp=0/0/0", rsp_valid_1, mem_data_out_1, mem_excpt_1);
      end
   endtask

   initial begin
      rst_b = 1'b0;
      req_valid = 1'b0; mem_addr = '0; mem_write_en = '0; mem_data_in = '0;
      req_valid_1 = 1'b0; mem_addr_1 = '0; mem_write_en_1 = '0; mem_data_in_1 = '0;
      test_reset();
      test_write_read();
      test_partial();
      test_out_of_range();
      test_back_to_back();
      test_reset_mid();
      test_random();
      test_latency1();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
